// File: rtl/hp_pkg.sv
// Shared constants for the phase-glitch detector array.
// Pure definitions; no logic, latency or flow control.
package hp_pkg;

  localparam int CNT_W_DEF = 8;
  // Arm counter width; holds STARTUP values up to 15.
  localparam int ARM_W = 4;

  function automatic longint unsigned cnt_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/hp_chan.sv
// One detector channel: modulator, B/A stages, raw alarm, edge detect, sticky, counter; alarm is combinational, flags/counter 1 CK.
// No backpressure. HP_EVENT_COUNT_EN adds the saturating event counter; otherwise cnt is tied to 0.
module hp_chan
  import hp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vcc,
  input  logic             upd_b,
  input  logic             arm,
  input  logic             glitch,
  input  logic             clr,
  output logic             alarm,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  logic data_q, data_d;
  logic b_q, b_d;
  logic a_q, a_d;
  logic alarm_q, alarm_d;
  logic sticky_q, sticky_d;
  logic raw;
  logic ev;

  always_comb begin
    data_d = data_q;
    b_d    = b_q;
    a_d    = a_q;
    if (upd_b) begin
      data_d = vcc ? ~data_q : 1'b0;
      b_d    = vcc ? (data_q ^ glitch) : 1'b0;
    end else begin
      a_d = vcc ? b_q : 1'b0;
    end
    // Clean operation keeps A==B and B==~Data; a flipped sample breaks the second.
    raw      = ~(b_q ^ a_q) & ~((data_q ^ glitch) ^ b_q);
    alarm    = raw & arm & vcc;
    alarm_d  = alarm;
    ev       = alarm & ~alarm_q;
    sticky_d = sticky_q;
    if (ev) begin
      sticky_d = 1'b1;
    end else if (clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= 1'b0;
      b_q      <= 1'b0;
      a_q      <= 1'b0;
      alarm_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      b_q      <= b_d;
      a_q      <= a_d;
      alarm_q  <= alarm_d;
      sticky_q <= sticky_d;
    end
  end

  assign sticky = sticky_q;

`ifdef HP_EVENT_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ev) begin
      if (clr) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`else
  assign cnt = '0;
`endif

endmodule

// File: rtl/hp_array.sv
// NCH phase-glitch detectors sharing CK2 and startup arming; Alarm comb, sticky/cnt 1 CK, trip 1 CK after cnt. No backpressure.
// HP_EVENT_COUNT_EN: per-channel counters and THRESH trip; undefined: cnt=0 and trip follows |sticky.
module hp_array
  import hp_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int INVERT  = 0,
  parameter int STARTUP = 3,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int THRESH  = 1
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 VCC,
  input  logic [NCH-1:0]       glitch,
  input  logic                 clr,
  output logic [NCH-1:0]       Alarm,
  output logic                 alarm_any,
  output logic [NCH-1:0]       sticky,
  output logic [NCH*CNT_W-1:0] cnt,
  output logic                 trip
);

  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("hp_array: NCH out of range");
  end
  if (STARTUP < 1 || STARTUP > 15) begin : g_bad_startup
    $error("hp_array: STARTUP out of range");
  end
  if (THRESH < 1 || longint'(THRESH) > longint'(cnt_max(CNT_W))) begin : g_bad_thresh
    $error("hp_array: THRESH out of range");
  end

  logic             ck2_q, ck2_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             trip_q, trip_d;
  logic             arm;
  logic             upd_b;

  assign upd_b = (ck2_q == (INVERT != 0));
  assign arm   = (arm_cnt_q == ARM_W'(STARTUP));

  always_comb begin
    ck2_d     = ~ck2_q;
    arm_cnt_d = arm_cnt_q;
    // A CK2 rising edge is any CK edge taken while CK2 is low.
    if (!VCC) begin
      arm_cnt_d = '0;
    end else if (!ck2_q && !arm) begin
      arm_cnt_d = arm_cnt_q + ARM_W'(1);
    end
`ifdef HP_EVENT_COUNT_EN
    trip_d = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (cnt[i*CNT_W +: CNT_W] >= CNT_W'(THRESH)) begin
        trip_d = 1'b1;
      end
    end
`else
    trip_d = |sticky;
`endif
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      ck2_q     <= 1'b0;
      arm_cnt_q <= '0;
      trip_q    <= 1'b0;
    end else begin
      ck2_q     <= ck2_d;
      arm_cnt_q <= arm_cnt_d;
      trip_q    <= trip_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    hp_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk    (CK),
      .rst    (RST),
      .vcc    (VCC),
      .upd_b  (upd_b),
      .arm    (arm),
      .glitch (glitch[i]),
      .clr    (clr),
      .alarm  (Alarm[i]),
      .sticky (sticky[i]),
      .cnt    (cnt[i*CNT_W +: CNT_W])
    );
  end

  assign alarm_any = |Alarm;
  assign trip      = trip_q;

endmodule

// File: tb/tb_hp_array.sv
// Directed bench for hp_array: a default instance plus a CNT_W=2 instance sharing all stimulus.
// Expected counter values follow HP_EVENT_COUNT_EN; sticky, Alarm and trip are build-independent.
module tb_hp_array;

`ifdef HP_EVENT_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        CK;
  logic        RST;
  logic        VCC;
  logic [3:0]  glitch;
  logic        clr;
  logic [3:0]  Alarm;
  logic        alarm_any;
  logic [3:0]  sticky;
  logic [31:0] cnt;
  logic        trip;
  logic [3:0]  w2_alarm;
  logic        w2_alarm_any;
  logic [3:0]  w2_sticky;
  logic [7:0]  w2_cnt;
  logic        w2_trip;

  int   n_chk;
  int   n_fail;
  bit   ph;
  logic [3:0] seen;
  logic [3:0] sticky_ev;
  logic       trip_ev;
  logic       trip_nx;

  hp_array u_dut (
    .CK        (CK),
    .RST       (RST),
    .VCC       (VCC),
    .glitch    (glitch),
    .clr       (clr),
    .Alarm     (Alarm),
    .alarm_any (alarm_any),
    .sticky    (sticky),
    .cnt       (cnt),
    .trip      (trip)
  );

  hp_array #(
    .CNT_W (2)
  ) u_dut_w2 (
    .CK        (CK),
    .RST       (RST),
    .VCC       (VCC),
    .glitch    (glitch),
    .clr       (clr),
    .Alarm     (w2_alarm),
    .alarm_any (w2_alarm_any),
    .sticky    (w2_sticky),
    .cnt       (w2_cnt),
    .trip      (w2_trip)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ph mirrors CK2: cleared by reset, toggled by every other edge.
  task automatic tick();
    @(posedge CK);
    ph = RST ? 1'b0 : ~ph;
    #1;
  endtask

  // Two-CK glitch launched just after a CK2 rise: one continuous Alarm, one event.
  task automatic pulse(input logic [3:0] m, input bit clr_ev);
    if (ph == 1'b0) tick();
    glitch = m;
    #1;
    chk("pulse_pre", 32'(Alarm), 32'd0);
    tick();
    chk("pulse_rise", 32'(Alarm), 32'(m));
    chk("pulse_any", 32'(alarm_any), 32'd1);
    clr = clr_ev;
    tick();
    clr       = 1'b0;
    glitch    = 4'b0000;
    sticky_ev = sticky;
    trip_ev   = trip;
    #1;
    chk("pulse_hold", 32'(Alarm), 32'(m));
    tick();
    trip_nx = trip;
    tick();
    chk("pulse_fall", 32'(Alarm), 32'd0);
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    ph     = 1'b0;
    RST    = 1'b1;
    VCC    = 1'b1;
    glitch = 4'b0000;
    clr    = 1'b0;

    tick();
    tick();
    chk("rst_alarm", 32'(Alarm), 32'd0);
    chk("rst_any", 32'(alarm_any), 32'd0);
    chk("rst_sticky", 32'(sticky), 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_trip", 32'(trip), 32'd0);
    chk("rst_w2_cnt", 32'(w2_cnt), 32'd0);

    // Glitch while still arming: raw alarm fires but must stay masked.
    RST = 1'b0;
    tick();
    glitch = 4'b0001;
    #1;
    seen = Alarm;
    tick();
    seen |= Alarm;
    tick();
    seen |= Alarm;
    glitch = 4'b0000;
    #1;
    seen |= Alarm;
    repeat (64) begin
      tick();
      seen |= Alarm;
    end
    chk("quiet_alarm", 32'(seen), 32'd0);
    chk("quiet_any", 32'(alarm_any), 32'd0);
    chk("quiet_sticky", 32'(sticky), 32'd0);
    chk("quiet_cnt", cnt, 32'd0);
    chk("quiet_trip", 32'(trip), 32'd0);

    pulse(4'b0010, 1'b0);
    chk("ch1_sticky_at_ev", 32'(sticky_ev), 32'h2);
    chk("ch1_trip_at_ev", 32'(trip_ev), 32'd0);
    chk("ch1_trip_next", 32'(trip_nx), 32'd1);
    chk("ch1_sticky", 32'(sticky), 32'h2);
    chk("ch1_cnt", cnt, CNT_ON ? 32'h0000_0100 : 32'h0);
    chk("ch1_w2_cnt", 32'(w2_cnt), CNT_ON ? 32'h04 : 32'h0);

    repeat (5) pulse(4'b0100, 1'b0);
    chk("ch2_sticky", 32'(sticky), 32'h6);
    chk("ch2_cnt", cnt, CNT_ON ? 32'h0005_0100 : 32'h0);
    chk("ch2_w2_sat", 32'(w2_cnt), CNT_ON ? 32'h34 : 32'h0);
    chk("ch2_w2_sticky", 32'(w2_sticky), 32'h6);
    chk("ch2_trip", 32'(trip), 32'd1);

    // Supply drop with ch0 glitch held; flags retained, re-arm needs 3 CK2 rises.
    VCC    = 1'b0;
    glitch = 4'b0001;
    #1;
    seen = Alarm;
    repeat (4) begin
      tick();
      seen |= Alarm;
    end
    chk("vcc_low_alarm", 32'(seen), 32'd0);
    chk("vcc_low_sticky", 32'(sticky), 32'h6);
    chk("vcc_low_cnt", cnt, CNT_ON ? 32'h0005_0100 : 32'h0);
    chk("vcc_low_trip", 32'(trip), 32'd1);
    VCC = 1'b1;
    tick();
    seen |= Alarm;
    if (ph == 1'b0) begin
      tick();
      seen |= Alarm;
    end
    glitch = 4'b0000;
    #1;
    seen |= Alarm;
    repeat (4) begin
      tick();
      seen |= Alarm;
    end
    chk("vcc_rearm_alarm", 32'(seen), 32'd0);
    chk("vcc_rearm_sticky", 32'(sticky), 32'h6);
    pulse(4'b0001, 1'b0);
    chk("vcc_armed_sticky", 32'(sticky), 32'h7);
    chk("vcc_armed_cnt", cnt, CNT_ON ? 32'h0005_0101 : 32'h0);

    repeat (5) pulse(4'b1000, 1'b0);
    chk("ch3_cnt", cnt, CNT_ON ? 32'h0505_0101 : 32'h0);
    chk("ch3_sticky", 32'(sticky), 32'hF);
    pulse(4'b1000, 1'b1);
    chk("clr_ev_sticky", 32'(sticky), 32'h8);
    chk("clr_ev_cnt", cnt, CNT_ON ? 32'h0100_0000 : 32'h0);
    chk("clr_ev_w2_cnt", 32'(w2_cnt), CNT_ON ? 32'h40 : 32'h0);
    chk("clr_ev_trip", 32'(trip), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_sticky", 32'(sticky), 32'd0);
    chk("clr_cnt", cnt, 32'd0);
    chk("clr_trip_lag", 32'(trip), 32'd1);
    tick();
    chk("clr_trip", 32'(trip), 32'd0);

    repeat (7) pulse(4'b0001, 1'b0);
    chk("ch0_cnt7", cnt, CNT_ON ? 32'h0000_0007 : 32'h0);
    chk("ch0_w2_cnt", 32'(w2_cnt), CNT_ON ? 32'h03 : 32'h0);
    chk("ch0_trip", 32'(trip), 32'd1);
    if (ph == 1'b0) tick();
    glitch = 4'b0001;
    tick();
    chk("mid_alarm", 32'(Alarm), 32'h1);
    RST = 1'b1;
    tick();
    chk("mid_rst_alarm", 32'(Alarm), 32'd0);
    chk("mid_rst_any", 32'(alarm_any), 32'd0);
    chk("mid_rst_sticky", 32'(sticky), 32'd0);
    chk("mid_rst_cnt", cnt, 32'd0);
    chk("mid_rst_trip", 32'(trip), 32'd0);
    chk("mid_rst_w2_cnt", 32'(w2_cnt), 32'd0);
    RST    = 1'b0;
    glitch = 4'b0000;
    repeat (4) tick();
    chk("post_rst_alarm", 32'(Alarm), 32'd0);
    chk("post_rst_sticky", 32'(sticky), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
